// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 @ 25 MHz timing constants and the sync-decoder FSM state type.
// The VGA timing generator and the sync decoder both import this package so
// the line/frame geometry is defined in exactly one place.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal geometry, in pixels
  localparam int HD = 640;  // display
  localparam int HB = 16;   // display end -> hsync start
  localparam int HR = 96;   // hsync pulse width
  localparam int HF = 48;   // hsync end -> next display start
  localparam int HT = HD + HB + HR + HF;  // 800

  // Vertical geometry, in lines
  localparam int VD = 480;
  localparam int VB = 10;
  localparam int VR = 2;
  localparam int VF = 33;
  localparam int VT = VD + VB + VR + VF;  // 525

  // Decoder acquisition states
  typedef enum logic [1:0] {
    SEARCH = 2'd0,  // waiting for the first hsync edge
    HACQ   = 2'd1,  // qualifying consecutive lines
    VACQ   = 2'd2,  // qualifying one full frame
    LOCKED = 2'd3   // line and frame timing confirmed
  } sync_state_e;

endpackage

// File: rtl/vga_sync_meter.sv
// -----------------------------------------------------------------------------
// vga_sync_meter
// Period and low-width counter for an active-low sync pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : counting enable (one unit of time)
//   sync       : sync level, active low
//   fall       : falling edge of sync (must coincide with a step or be a
//                standalone event)
//   period     : steps since the last fall, saturating
//   width      : steps with sync low since the last fall, saturating
// The fall sample itself counts as the first unit of both measurements, so a
// pulse train with period P and low width R reads exactly P and R at the next
// fall.
// -----------------------------------------------------------------------------
module vga_sync_meter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         sync,
  input  logic         fall,
  output logic [W-1:0] period,
  output logic [W-1:0] width
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every register in
  // the clock domain samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      width  <= '0;
    end else if (fall) begin
      period <= {{(W-1){1'b0}}, step};
      width  <= {{(W-1){1'b0}}, step};
    end else if (step) begin
      if (period != CNT_MAX) period <= period + W'(1);
      if (!sync && width != CNT_MAX) width <= width + W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
// Sink-side VGA timing recovery: consumes active-low hsync/vsync, rebuilds the
// pixel raster position, qualifies line and frame timing and reports lock.
//   clock_25  : system clock
//   reset_key : asynchronous active-low reset
//   pixel_ce  : pixel clock enable; nothing samples or counts without it
//   vga_hs    : horizontal sync, active low
//   vga_vs    : vertical sync, active low
//   pixel_x   : recovered column 0..HT-1, one clock after the sampling edge
//   pixel_y   : recovered line 0..VT-1
//   video_on  : locked and inside the visible HD x VD window
//   locked    : timing lock achieved
//   sync_err  : one-clock pulse on a timing violation outside SEARCH
//   err_count : (only with SYNC_ERR_COUNT_EN) saturating count of sync_err
//               pulses, cleared only by reset
// Optional feature macro: SYNC_ERR_COUNT_EN
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int HD         = vga_timing_pkg::HD,
  parameter int HB         = vga_timing_pkg::HB,
  parameter int HR         = vga_timing_pkg::HR,
  parameter int HF         = vga_timing_pkg::HF,
  parameter int VD         = vga_timing_pkg::VD,
  parameter int VB         = vga_timing_pkg::VB,
  parameter int VR         = vga_timing_pkg::VR,
  parameter int VF         = vga_timing_pkg::VF,
  parameter int LOCK_LINES = 4
) (
  input  logic       clock_25,
  input  logic       reset_key,
  input  logic       pixel_ce,
  input  logic       vga_hs,
  input  logic       vga_vs,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       locked,
  output logic       sync_err
`ifdef SYNC_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = HD + HB + HR + HF;
  localparam int V_TOTAL = VD + VB + VR + VF;
  localparam int MW      = 11;

  localparam logic [9:0]    X_LOAD = 10'(HD + HB);
  localparam logic [9:0]    Y_LOAD = 10'(VD + VB);
  localparam logic [9:0]    X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [7:0]    LL     = 8'(LOCK_LINES);
  localparam logic [MW-1:0] H_TMO  = MW'(2 * H_TOTAL);

  logic          hs_prev, vs_prev;
  logic          hs_fall, vs_fall;
  logic [MW-1:0] h_period, hs_width, v_lines, vs_width;
  logic          line_bad, frame_bad, frame_good, timeout;
  sync_state_e   state;
  logic [7:0]    good_lines;

  assign hs_fall = pixel_ce & hs_prev & ~vga_hs;
  assign vs_fall = pixel_ce & vs_prev & ~vga_vs;

  // Horizontal: one step per pixel. Vertical: one step per line (hs fall).
  vga_sync_meter #(.W(MW)) h_meter (
    .clk    (clock_25),
    .rst_n  (reset_key),
    .step   (pixel_ce),
    .sync   (vga_hs),
    .fall   (hs_fall),
    .period (h_period),
    .width  (hs_width)
  );

  vga_sync_meter #(.W(MW)) v_meter (
    .clk    (clock_25),
    .rst_n  (reset_key),
    .step   (hs_fall),
    .sync   (vga_vs),
    .fall   (vs_fall),
    .period (v_lines),
    .width  (vs_width)
  );

  // Judgements are only meaningful at the corresponding falling edge.
  assign line_bad   = hs_fall && !(h_period == MW'(H_TOTAL) && hs_width == MW'(HR));
  assign frame_good = (v_lines == MW'(V_TOTAL)) && (vs_width == MW'(VR));
  assign frame_bad  = vs_fall && !frame_good;
  assign timeout    = pixel_ce && (h_period >= H_TMO);

  // Edge history and raster counters; a sync fall re-phases its counter.
  always_ff @(posedge clock_25 or negedge reset_key) begin
    if (!reset_key) begin
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pixel_ce) begin
      hs_prev <= vga_hs;
      vs_prev <= vga_vs;
      if (hs_fall)                pixel_x <= X_LOAD;
      else if (pixel_x == X_LAST) pixel_x <= '0;
      else                        pixel_x <= pixel_x + 10'd1;
      if (vs_fall)                pixel_y <= Y_LOAD;
      else if (pixel_x == X_LAST) pixel_y <= (pixel_y == Y_LAST) ? '0 : pixel_y + 10'd1;
    end
  end

  // Acquisition FSM with registered locked/sync_err.
  always_ff @(posedge clock_25 or negedge reset_key) begin
    if (!reset_key) begin
      state      <= SEARCH;
      good_lines <= '0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      // NOTE: sync_err is given its default before the case so every path
      // assigns it, which keeps the error a single-clock pulse.
      sync_err <= 1'b0;
      if (pixel_ce) begin
        unique case (state)
          SEARCH: begin
            // The first edge only starts the period measurement.
            if (hs_fall) begin
              state      <= HACQ;
              good_lines <= '0;
            end
          end
          HACQ: begin
            if (hs_fall) begin
              if (line_bad)              good_lines <= '0;
              else if (good_lines != LL) good_lines <= good_lines + 8'd1;
            end
            if (vs_fall && good_lines == LL && !line_bad) state <= VACQ;
          end
          VACQ: begin
            if (line_bad || frame_bad) begin
              state    <= SEARCH;
              sync_err <= 1'b1;
            end else if (vs_fall) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_bad || frame_bad) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              sync_err <= 1'b1;
            end
          end
        endcase
        // Stuck or missing hsync: no edge for two full lines.
        if (state != SEARCH && timeout) begin
          state    <= SEARCH;
          locked   <= 1'b0;
          sync_err <= 1'b1;
        end
      end
    end
  end

  assign video_on = locked && (pixel_x < 10'(HD)) && (pixel_y < 10'(VD));

`ifdef SYNC_ERR_COUNT_EN
  always_ff @(posedge clock_25 or negedge reset_key) begin
    if (!reset_key)                        err_count <= '0;
    else if (sync_err && err_count != '1)  err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Drives a behavioural VGA generator (pixel_ce alternating) into the decoder.
// A scaled-down raster (25 x 13) keeps every scenario a few hundred pixels
// long while preserving the porch/pulse structure of 640x480.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HD = 16, HB = 2, HR = 4, HF = 3;
  localparam int VD = 6,  VB = 2, VR = 2, VF = 3;
  localparam int LL = 4;
  localparam int HT = HD + HB + HR + HF;  // 25
  localparam int VT = VD + VB + VR + VF;  // 13
  localparam int HS0 = HD + HB;           // first hsync-low column
  localparam int VS0 = VD + VB;           // first vsync-low line
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pixel_ce = 1'b0;
  logic       vga_hs = 1'b1;
  logic       vga_vs = 1'b1;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, locked, sync_err;
`ifdef SYNC_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  vga_sync_decoder #(
    .HD(HD), .HB(HB), .HR(HR), .HF(HF),
    .VD(VD), .VB(VB), .VR(VR), .VF(VF),
    .LOCK_LINES(LL)
  ) dut (
    .clock_25  (clk),
    .reset_key (rst_n),
    .pixel_ce  (pixel_ce),
    .vga_hs    (vga_hs),
    .vga_vs    (vga_vs),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .locked    (locked),
    .sync_err  (sync_err)
`ifdef SYNC_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Generator state; hs_len and frame_len are one-shot overrides that revert
  // at the next line / frame wrap.
  int gx = 0, gy = 0;
  int hs_len = HR;
  int frame_len = VT;
  bit hs_stuck = 1'b0;
  int smp_x = 0, smp_y = 0;
  int err_pulses = 0;

  always @(posedge clk) begin
    #5;
    if (sync_err === 1'b1) err_pulses++;
  end

  // One pixel: a ce clock carrying (gx,gy), then an idle clock. Returns at the
  // negedge after the ce edge, with outputs reflecting that pixel.
  task automatic pix();
    @(negedge clk);
    pixel_ce = 1'b1;
    vga_hs = !(!hs_stuck && gx >= HS0 && gx < HS0 + hs_len);
    vga_vs = !(gy >= VS0 && gy < VS0 + VR);
    smp_x = gx;
    smp_y = gy;
    @(negedge clk);
    pixel_ce = 1'b0;
    gx++;
    if (gx == HT) begin
      gx = 0;
      hs_len = HR;
      gy++;
      if (gy >= frame_len) begin
        gy = 0;
        frame_len = VT;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) pix();
  endtask

  task automatic wait_lock(input string name, input int budget, output int steps);
    steps = 0;
    while (locked !== 1'b1 && steps < budget) begin
      pix();
      steps++;
    end
    check(name, locked, 1'b1);
  endtask

  task automatic align(input string name, input int x, input int y);
    int n;
    n = 0;
    do begin
      pix();
      n++;
    end while (!(smp_x == x && smp_y == y) && n <= FRAME + 1);
    if (!(smp_x == x && smp_y == y)) check({name, "_align"}, 0, 1);
  endtask

  typedef struct {
    int x;
    int y;
    logic exp_video;
  } vid_vec_t;

  typedef struct {
    string name;
    int    hs_len;
    int    frame_len;
    int    settle_lines;
    int    exp_errs;
    logic  exp_locked;
  } err_vec_t;

  vid_vec_t vid_tab[6];
  err_vec_t err_tab[3];

  initial begin
    int steps, mism, von, e0;

    vid_tab[0] = '{0,      0,      1'b1};
    vid_tab[1] = '{HD - 1, VD - 1, 1'b1};
    vid_tab[2] = '{HD,     0,      1'b0};
    vid_tab[3] = '{0,      VD,     1'b0};
    vid_tab[4] = '{HT - 1, VT - 1, 1'b0};
    vid_tab[5] = '{HS0,    3,      1'b0};

    err_tab[0] = '{"hs_stretch", HR + 1, VT,     2,      1, 1'b0};
    err_tab[1] = '{"hs_shrink",  HR - 1, VT,     2,      1, 1'b0};
    err_tab[2] = '{"short_frm",  HR,     VT - 1, 2 * VT, 1, 1'b0};

    // Reset state
    #5 rst_n = 1'b0;
    #50;
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_locked", locked, 0);
    check("rst_video", video_on, 0);
    check("rst_err", sync_err, 0);
    @(negedge clk) rst_n = 1'b1;

    // Acquisition: 4 good lines, vsync, then one qualified frame.
    // Lock lands on the ce edge of frame 1, line VS0, column 0.
    wait_lock("initial_lock", 3 * FRAME, steps);
    check("lock_latency", steps, FRAME + VS0 * HT + 1);
    check("acq_errs", err_pulses, 0);

    // One full frame: raster follows the generator, video window size exact.
    mism = 0;
    von = 0;
    e0 = err_pulses;
    for (int i = 0; i < FRAME; i++) begin
      pix();
      if (pixel_x !== 10'(smp_x) || pixel_y !== 10'(smp_y)) mism++;
      if (video_on === 1'b1) von++;
    end
    check("raster_mismatches", mism, 0);
    check("video_count", von, HD * VD);
    check("frame_errs", err_pulses - e0, 0);

    // Video window spot checks
    foreach (vid_tab[i]) begin
      align("video_pt", vid_tab[i].x, vid_tab[i].y);
      check($sformatf("video_%0d_%0d", vid_tab[i].x, vid_tab[i].y), video_on, vid_tab[i].exp_video);
    end

    // Timing faults while locked; each must raise one error, drop lock, relock.
    foreach (err_tab[i]) begin
      align(err_tab[i].name, 0, 0);
      hs_len = err_tab[i].hs_len;
      frame_len = err_tab[i].frame_len;
      e0 = err_pulses;
      run(err_tab[i].settle_lines * HT);
      check({err_tab[i].name, "_errs"}, err_pulses - e0, err_tab[i].exp_errs);
      check({err_tab[i].name, "_locked"}, locked, err_tab[i].exp_locked);
      wait_lock({err_tab[i].name, "_relock"}, 3 * FRAME, steps);
    end

    // Stuck-high hsync: timeout after 2*HT pixels without an edge.
    align("tmo", 0, 1);
    hs_stuck = 1'b1;
    e0 = err_pulses;
    run(2 * HT + 4);
    check("timeout_errs", err_pulses - e0, 1);
    check("timeout_locked", locked, 0);
    hs_stuck = 1'b0;
    wait_lock("timeout_relock", 3 * FRAME, steps);

`ifdef SYNC_ERR_COUNT_EN
    check("err_count", err_count, 4);
`endif

    // Asynchronous reset mid-line while locked.
    align("rst_mid", 5, 2);
    #5 rst_n = 1'b0;
    #2;
    check("arst_x", pixel_x, 0);
    check("arst_y", pixel_y, 0);
    check("arst_locked", locked, 0);
    check("arst_video", video_on, 0);
    check("arst_err", sync_err, 0);
`ifdef SYNC_ERR_COUNT_EN
    check("arst_err_count", err_count, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    e0 = err_pulses;
    align("post_rst", HS0, 2);
    check("post_rst_x", pixel_x, HS0);
    check("post_rst_locked", locked, 0);
    check("post_rst_errs", err_pulses - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
